// File: rtl/nic_rx_credit_receiver.sv
// rtl/nic_rx_credit_receiver.sv - credit-based packet receive buffer (optional NIC_RX_OVERFLOW_CHECK_EN)
module nic_rx_credit_receiver #(
   parameter int FLIT_WIDTH   = 32,
   parameter int PACKET_FLITS = 5,
   parameter int PACKET_SLOTS = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flit_valid_din,
   input  logic [FLIT_WIDTH-1:0] flit_din,
   input  logic                  flit_pop_din,
   output logic                  packet_available_dout,
   output logic [FLIT_WIDTH-1:0] flit_dout,
   output logic                  last_flit_dout,
   output logic                  credit_out_dout,
   output logic                  overflow_error_dout
);

   localparam int DEPTH  = PACKET_SLOTS * PACKET_FLITS;
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int PKT_W  = $clog2(PACKET_SLOTS + 1);
   localparam int FCNT_W = $clog2(PACKET_FLITS + 1);

   typedef enum logic {HEADER, BODY} wr_state_t;

   logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
   wr_state_t             r_state;
   wr_state_t             w_state_nxt;
   logic [FCNT_W-1:0]     r_wcnt;
   logic [FCNT_W-1:0]     w_wcnt_nxt;
   logic [FCNT_W-1:0]     r_rcnt;
   logic [PTR_W-1:0]      r_wptr;
   logic [PTR_W-1:0]      r_rptr;
   logic [CNT_W-1:0]      r_count;
   logic [PKT_W-1:0]      r_pkt;
   logic                  r_credit;
   logic                  w_avail;
   logic                  w_last;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_accept;
   logic                  w_wr_done;

   // A pop frees a slot in the same cycle, so a full buffer still accepts a flit alongside a pop.
   assign w_avail  = (r_pkt != '0);
   assign w_last   = w_avail && (r_rcnt == FCNT_W'(PACKET_FLITS - 1));
   assign w_pop    = flit_pop_din && w_avail;
   assign w_full   = (r_count == CNT_W'(DEPTH));
   assign w_accept = flit_valid_din && (!w_full || w_pop);

   assign flit_dout             = r_mem[r_rptr];
   assign packet_available_dout = w_avail && !reset;
   assign last_flit_dout        = w_last && !reset;
   assign credit_out_dout       = r_credit && !reset;

   // Write-side FSM state and flit counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= HEADER;
         r_wcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_wcnt  <= w_wcnt_nxt;
      end
   end

   // Write-side next state: header loads the counter, body counts down to packet completion.
   always_comb begin
      w_state_nxt = r_state;
      w_wcnt_nxt  = r_wcnt;
      w_wr_done   = 1'b0;
      if (w_accept) begin
         case (r_state)
            HEADER: begin
               if (PACKET_FLITS == 1) begin
                  w_wr_done = 1'b1;
               end else begin
                  w_wcnt_nxt  = FCNT_W'(PACKET_FLITS - 1);
                  w_state_nxt = BODY;
               end
            end
            BODY: begin
               w_wcnt_nxt = r_wcnt - FCNT_W'(1);
               if (r_wcnt == FCNT_W'(1)) begin
                  w_wr_done   = 1'b1;
                  w_state_nxt = HEADER;
               end
            end
            default: w_state_nxt = HEADER;
         endcase
      end
   end

   // Flit storage; contents survive reset on purpose.
   always_ff @(posedge clk) begin
      if (!reset && w_accept) begin
         r_mem[r_wptr] <= flit_din;
      end
   end

   // Pointers, occupancy, packet count, read position and the registered credit pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_pkt    <= '0;
         r_rcnt   <= '0;
         r_credit <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
            r_rcnt <= w_last ? '0 : r_rcnt + FCNT_W'(1);
         end
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         case ({w_wr_done, w_pop && w_last})
            2'b10:   r_pkt <= r_pkt + PKT_W'(1);
            2'b01:   r_pkt <= r_pkt - PKT_W'(1);
            default: r_pkt <= r_pkt;
         endcase
         r_credit <= w_pop && w_last;
      end
   end

`ifdef NIC_RX_OVERFLOW_CHECK_EN
   logic r_ovf;
   logic w_drop;

   assign w_drop              = flit_valid_din && !w_accept;
   assign overflow_error_dout = r_ovf && !reset;

   // Sticky flag set the cycle after any dropped flit, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end
   end
`else
   assign overflow_error_dout = 1'b0;
`endif

endmodule

// File: tb/tb_nic_rx_credit_receiver.sv
// tb/tb_nic_rx_credit_receiver.sv - directed self-checking bench for nic_rx_credit_receiver
module tb_nic_rx_credit_receiver;

   logic        clk = 1'b0;
   logic        reset;
   logic        flit_valid_din;
   logic [31:0] flit_din;
   logic        flit_pop_din;
   logic        packet_available_dout;
   logic [31:0] flit_dout;
   logic        last_flit_dout;
   logic        credit_out_dout;
   logic        overflow_error_dout;

   int checks   = 0;
   int errors   = 0;
   int credits  = 0;
   int spurious = 0;
   logic exp_ovf;

   nic_rx_credit_receiver dut (
      .clk                   (clk),
      .reset                 (reset),
      .flit_valid_din        (flit_valid_din),
      .flit_din              (flit_din),
      .flit_pop_din          (flit_pop_din),
      .packet_available_dout (packet_available_dout),
      .flit_dout             (flit_dout),
      .last_flit_dout        (last_flit_dout),
      .credit_out_dout       (credit_out_dout),
      .overflow_error_dout   (overflow_error_dout)
   );

   always #5 clk = ~clk;

   // Credit pulses are counted on the falling edge, where outputs are stable.
   always @(negedge clk) begin
      if (credit_out_dout) credits++;
      if (reset && credit_out_dout) spurious++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic push(input logic [31:0] d);
      flit_valid_din = 1'b1;
      flit_din       = d;
      step();
      flit_valid_din = 1'b0;
   endtask

   task automatic pop_check(input string tag, input logic [31:0] d, input logic lst);
      check({tag, "_data"}, flit_dout, d);
      check({tag, "_last"}, {31'd0, last_flit_dout}, {31'd0, lst});
      flit_pop_din = 1'b1;
      step();
      flit_pop_din = 1'b0;
   endtask

   initial begin
`ifdef NIC_RX_OVERFLOW_CHECK_EN
      exp_ovf = 1'b1;
`else
      exp_ovf = 1'b0;
`endif
      reset = 1'b1; flit_valid_din = 1'b0; flit_din = '0; flit_pop_din = 1'b0;
      step(); step();
      check("rst_avail",  {31'd0, packet_available_dout}, 0);
      check("rst_last",   {31'd0, last_flit_dout}, 0);
      check("rst_credit", {31'd0, credit_out_dout}, 0);
      check("rst_ovf",    {31'd0, overflow_error_dout}, 0);
      reset = 1'b0;
      step();

      // Single packet, back-to-back flits
      for (int i = 0; i < 5; i++) begin
         push(32'h10 + i);
         check("t1_avail", {31'd0, packet_available_dout}, (i == 4) ? 1 : 0);
      end
      for (int i = 0; i < 5; i++) pop_check("t1", 32'h10 + i, i == 4);
      check("t1_credit", {31'd0, credit_out_dout}, 1);
      check("t1_empty",  {31'd0, packet_available_dout}, 0);
      step();
      check("t1_credit_once", {31'd0, credit_out_dout}, 0);
      check("t1_credit_cnt", credits, 1);

      // Gapped packet: three idle cycles inside the packet
      for (int i = 0; i < 3; i++) push(32'h20 + i);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t2_gap_avail", {31'd0, packet_available_dout}, 0);
      end
      push(32'h23);
      check("t2_avail4", {31'd0, packet_available_dout}, 0);
      push(32'h24);
      check("t2_avail5", {31'd0, packet_available_dout}, 1);
      for (int i = 0; i < 5; i++) pop_check("t2", 32'h20 + i, i == 4);
      step();

      // Fill both slots, then one extra flit that must be dropped
      for (int i = 0; i < 10; i++) push(32'h30 + i);
      push(32'hFF);
      check("t3_ovf",   {31'd0, overflow_error_dout}, {31'd0, exp_ovf});
      check("t3_avail", {31'd0, packet_available_dout}, 1);
      for (int i = 0; i < 10; i++) pop_check("t3", 32'h30 + i, (i == 4) || (i == 9));
      step();
      check("t3_empty", {31'd0, packet_available_dout}, 0);
      check("t3_ovf_sticky", {31'd0, overflow_error_dout}, {31'd0, exp_ovf});
      check("t3_credit_cnt", credits, 4);

      // Last write of packet 2 coincides with last pop of packet 1; write pointer wraps 9->0
      for (int i = 0; i < 5; i++) push(32'h40 + i);
      for (int i = 0; i < 4; i++) push(32'h50 + i);
      for (int i = 0; i < 4; i++) pop_check("t4a", 32'h40 + i, 1'b0);
      check("t4_pre_data", flit_dout, 32'h44);
      check("t4_pre_last", {31'd0, last_flit_dout}, 1);
      flit_valid_din = 1'b1; flit_din = 32'h54; flit_pop_din = 1'b1;
      step();
      flit_valid_din = 1'b0; flit_pop_din = 1'b0;
      check("t4_avail", {31'd0, packet_available_dout}, 1);
      check("t4_credit", {31'd0, credit_out_dout}, 1);
      for (int i = 0; i < 5; i++) pop_check("t4b", 32'h50 + i, i == 4);
      step();
      check("t4_empty", {31'd0, packet_available_dout}, 0);
      check("t4_credit_cnt", credits, 6);

      // Reset in the middle of a packet
      for (int i = 0; i < 3; i++) push(32'h60 + i);
      reset = 1'b1;
      step();
      check("t5_rst_credit", {31'd0, credit_out_dout}, 0);
      check("t5_rst_avail",  {31'd0, packet_available_dout}, 0);
      step();
      reset = 1'b0;
      check("t5_ovf_clear", {31'd0, overflow_error_dout}, 0);
      for (int i = 0; i < 4; i++) push(32'h70 + i);
      check("t5_partial", {31'd0, packet_available_dout}, 0);
      push(32'h74);
      check("t5_avail", {31'd0, packet_available_dout}, 1);
      for (int i = 0; i < 5; i++) pop_check("t5", 32'h70 + i, i == 4);
      step();
      check("t5_empty", {31'd0, packet_available_dout}, 0);
      check("t5_credit_cnt", credits, 7);

      // Pop while nothing is available must be ignored
      flit_pop_din = 1'b1;
      step(); step();
      check("t6_credit", {31'd0, credit_out_dout}, 0);
      check("t6_avail",  {31'd0, packet_available_dout}, 0);
      flit_pop_din = 1'b0;
      for (int i = 0; i < 5; i++) push(32'h80 + i);
      for (int i = 0; i < 5; i++) pop_check("t6", 32'h80 + i, i == 4);
      step(); step();

      check("total_credits", credits, 8);
      check("no_reset_credit", spurious, 0);
      check("final_ovf", {31'd0, overflow_error_dout}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
